// File: rtl/addsub_pkg.sv
// Shared defaults, operation encodings and a wrap-around index helper
// for the shared add/sub arbiter.
package addsub_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // (idx + 1) mod n without requiring n to be a power of two
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester and result-port bundle; master drives requests and
// consumes results, slave is the shared add/sub unit.
interface addsub_arbiter_if import addsub_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dataa;
  logic [NUM_REQ*WIDTH-1:0] req_datab;
  logic [NUM_REQ-1:0]       req_add_sub;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_carry;

  modport master (
    output req_valid, req_dataa, req_datab, req_add_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_dataa, req_datab, req_add_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first active request found
// searching upward from ptr with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shared add/sub unit: round-robin issue from NUM_REQ requesters into a
// single result register with one-cycle latency and full throughput.
module addsub_arbiter import addsub_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  addsub_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] req_eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               slot_open;
  logic               fire;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               op;
  logic [WIDTH:0]     sum;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_carry_q;

  // Gating with rst keeps any transfer from being recorded during reset
  assign slot_open    = !rsp_valid_q || bus.rsp_ready;
  assign req_eligible = (slot_open && !rst) ? bus.req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign fire          = |grant;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_id = ID_W'(i);
    end
  end

  assign opa = bus.req_dataa[int'(gnt_id)*WIDTH +: WIDTH];
  assign opb = bus.req_datab[int'(gnt_id)*WIDTH +: WIDTH];
  assign op  = bus.req_add_sub[gnt_id];

  // Extra MSB is carry on add and borrow on subtract
  always_comb begin
    if (op == OP_ADD) sum = {1'b0, opa} + {1'b0, opb};
    else              sum = {1'b0, opa} - {1'b0, opb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else if (fire) begin
      ptr          <= ID_W'(next_index(int'(gnt_id), NUM_REQ));
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gnt_id;
      rsp_result_q <= sum[WIDTH-1:0];
      rsp_carry_q  <= sum[WIDTH];
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and randomized checks of the shared add/sub arbiter against
// hand-computed vectors and a small reference model.
module tb_addsub_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  addsub_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) bus ();

  addsub_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    bus.req_dataa[i*8 +: 8] = a;
    bus.req_datab[i*8 +: 8] = b;
    bus.req_add_sub[i]      = op;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [7:0] res, input logic c);
    check({tag, "_valid"},  bus.rsp_valid, v);
    check({tag, "_id"},     bus.rsp_id, id);
    check({tag, "_result"}, bus.rsp_result, res);
    check({tag, "_carry"},  bus.rsp_carry, c);
  endtask

  logic [1:0] seq_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] seq_res [6] = '{8'h03, 8'hF1, 8'h10, 8'h30, 8'h03, 8'hF1};
  logic       seq_c   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  logic [7:0] bv_a  [4] = '{8'h00, 8'h55, 8'h00, 8'hFF};
  logic [7:0] bv_b  [4] = '{8'h00, 8'h55, 8'hFF, 8'hFF};
  logic       bv_op [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] bv_r  [4] = '{8'h00, 8'h00, 8'h01, 8'hFE};
  logic       bv_c  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  int         mp;
  int         g;
  int         waitc [4];
  logic [3:0] eg;
  logic [3:0] vsnap;
  logic       exp_v;
  logic [1:0] exp_id;
  logic [7:0] exp_r;
  logic       exp_c;
  logic [8:0] full;
  logic [7:0] ra;
  logic [7:0] rb;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid   = '0;
    bus.req_dataa   = '0;
    bus.req_datab   = '0;
    bus.req_add_sub = '0;
    bus.rsp_ready   = 1'b1;
    tick();
    tick();

    // reset state, requests ignored while rst is high
    check_rsp("reset", 1'b0, 2'd0, 8'h00, 1'b0);
    bus.req_valid = 4'hF;
    #1;
    check("reset_ready", bus.req_ready, 4'h0);
    tick();
    check("reset_no_xfer", bus.rsp_valid, 1'b0);
    bus.req_valid = 4'h0;

    // requester 0: 0xFF + 0x01
    rst = 1'b0;
    set_req(0, 8'hFF, 8'h01, 1'b1);
    bus.req_valid = 4'b0001;
    #1;
    check("r0_ready", bus.req_ready, 4'b0001);
    tick();
    check_rsp("r0_add", 1'b1, 2'd0, 8'h00, 1'b1);
    bus.req_valid = 4'b0000;
    tick();
    check("r0_drain", bus.rsp_valid, 1'b0);

    // requester 2: subtracts
    set_req(2, 8'h00, 8'h01, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    check("r2_ready", bus.req_ready, 4'b0100);
    tick();
    check_rsp("r2_sub_borrow", 1'b1, 2'd2, 8'hFF, 1'b1);
    set_req(2, 8'h10, 8'h05, 1'b0);
    tick();
    check_rsp("r2_sub", 1'b1, 2'd2, 8'h0B, 1'b0);
    bus.req_valid = 4'b0000;
    tick();
    check("r2_drain", bus.rsp_valid, 1'b0);

    // fresh reset, then all four continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 8'h01, 8'h02, 1'b1);
    set_req(1, 8'h11, 8'h20, 1'b0);
    set_req(2, 8'h80, 8'h90, 1'b1);
    set_req(3, 8'h31, 8'h01, 1'b0);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
      tick();
      check_rsp("rr_seq", 1'b1, seq_id[k], seq_res[k], seq_c[k]);
    end

    // back-pressure freezes output and closes the slot
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", bus.req_ready, 4'h0);
      tick();
      check_rsp("stall_hold", 1'b1, 2'd1, 8'hF1, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_ready", bus.req_ready, 4'b0100);
    tick();
    check_rsp("release_rsp", 1'b1, 2'd2, 8'h10, 1'b1);

    // reset while a result is pending and requests are valid
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.req_ready, 4'h0);
    tick();
    check_rsp("midrst", 1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    check("postrst_ready", bus.req_ready, 4'b0001);
    tick();
    check_rsp("postrst_rsp", 1'b1, 2'd0, 8'h03, 1'b0);
    bus.req_valid = 4'h0;
    tick();

    // arithmetic boundaries on requester 3
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      set_req(3, bv_a[k], bv_b[k], bv_op[k]);
      #1;
      check("bound_ready", bus.req_ready, 4'b1000);
      tick();
      check_rsp("bound", 1'b1, 2'd3, bv_r[k], bv_c[k]);
    end
    bus.req_valid = 4'h0;

    // randomized traffic against a reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mp = 0;
    exp_v = 1'b0;
    exp_id = '0;
    exp_r = '0;
    exp_c = 1'b0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          set_req(i, ra, rb, 1'($urandom_range(0, 1)));
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg = '0;
      g = -1;
      if (!exp_v || bus.rsp_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && bus.req_valid[(mp + k) % 4]) g = (mp + k) % 4;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      check("rand_ready", bus.req_ready, eg);
      check("rand_onehot", ($countones(bus.req_ready) <= 1), 1'b1);
      vsnap = bus.req_valid;
      if (g >= 0) begin
        ra = bus.req_dataa[g*8 +: 8];
        rb = bus.req_datab[g*8 +: 8];
        if (bus.req_add_sub[g]) full = {1'b0, ra} + {1'b0, rb};
        else                    full = {1'b0, ra} - {1'b0, rb};
        for (int i = 0; i < 4; i++) begin
          if (i != g && vsnap[i]) begin
            waitc[i]++;
            check("rand_starve", (waitc[i] <= 3), 1'b1);
          end
        end
        waitc[g] = 0;
        exp_v  = 1'b1;
        exp_id = 2'(g);
        exp_r  = full[7:0];
        exp_c  = full[8];
        mp     = (g + 1) % 4;
      end else if (bus.rsp_ready) begin
        exp_v = 1'b0;
      end
      tick();
      if (g >= 0) bus.req_valid[g] = 1'b0;
      check("rand_valid", bus.rsp_valid, exp_v);
      if (exp_v) begin
        check("rand_id", bus.rsp_id, exp_id);
        check("rand_result", bus.rsp_result, exp_r);
        check("rand_carry", bus.rsp_carry, exp_c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
